if_fetch_mo: RTL and testbench
==============================

Name: if_fetch_mo

Overview:
- Next-generation instruction-fetch front end. Keeps up to MAX_OUTSTANDING inst_sram requests in flight and stores returned instructions in a BUF_DEPTH-entry instruction buffer.
- Sits between the branch/exception redirect logic and ID.
- Redirects discard stale responses through a discard counter, so no response is ever mis-tagged.
- Address translation is external: the block issues virtual fetch addresses on inst_sram_addr.

Parameters:
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests (1..8)
BUF_DEPTH, 4, instruction buffer entries (power of two, >= MAX_OUTSTANDING)
RESET_PC, 32'h1c000000, first fetch address after reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
br_valid  in  1  branch redirect pulse
br_target  in  32  branch target
flush  in  1  exception/ertn redirect pulse; priority over br_valid
flush_target  in  32  exception entry or return address
id_allowin  in  1  ID can accept an instruction
if_to_id_valid  out  1  head buffer entry valid
if_pc  out  32  head entry PC
if_inst  out  32  head entry instruction (0 when if_adef)
if_adef  out  1  head entry has a misaligned fetch address
inst_sram_req  out  1  fetch request
inst_sram_addr  out  32  fetch address (pc_next)
inst_sram_addr_ok  in  1  request accepted
inst_sram_data_ok  in  1  response valid (in order)
inst_sram_rdata  in  32  response data
Constant outputs: inst_sram_wr=0, inst_sram_size=2'b10, inst_sram_wstrb=0, inst_sram_wdata=0.

Behaviour:
- Reset: pc_next=RESET_PC; pending_cnt=0; discard_cnt=0; buffer empty; stop=0; all outputs 0.
- Counters:
  - pending_cnt counts live requests. Their PCs are held in a pending-PC FIFO of depth MAX_OUTSTANDING.
  - discard_cnt counts stale requests.
  - Invariant: pending_cnt + discard_cnt <= MAX_OUTSTANDING.
- Issue: inst_sram_req = ~reset & ~stop & ~redirect & (pending_cnt+discard_cnt < MAX_OUTSTANDING) & (pending_cnt+buf_cnt < BUF_DEPTH) & (pc_next[1:0]==0).
- On req & addr_ok: push pc_next into the pending-PC FIFO; pc_next += 4, wrapping mod 2^32.
- Misaligned pc_next with no redirect:
  - No request is issued.
  - Once pending_cnt==0 and the buffer is not full, push {pc_next, inst=0, adef=1} into the buffer.
  - Set stop=1, which holds until the next redirect.
- Response on data_ok:
  - If discard_cnt>0: decrement discard_cnt and drop rdata.
  - Otherwise: pop the pending-PC FIFO and push {pc, rdata, adef=0} into the buffer. The buffer never overflows because of the credit check at issue.
- Output: if_to_id_valid = buffer non-empty. Pop when if_to_id_valid & id_allowin. Without bypass, an instruction reaches ID 1 cycle after data_ok.
- Redirect (redirect = flush | br_valid; target = flush ? flush_target : br_target). Same cycle:
  - No request is issued.
  - Next cycle: pc_next=target; stop=0; buffer cleared; pending FIFO cleared.
  - discard_cnt becomes pending_cnt + discard_cnt − (1 if this cycle's data_ok hits a non-discarded request or consumes a discard).
  - A data_ok in the redirect cycle is dropped.
  - An ID pop in the redirect cycle is still a valid transfer.
- Simultaneous push and pop on a full buffer is legal. Simultaneous issue and response updates all counters net.
- Reset mid-operation: all state returns to reset values. Responses still in flight from inst_sram after reset are not supported; the bench must reset the memory model too.

Optional Feature:
- Macro IF_BYPASS_EN.
- Defined: when the buffer is empty and a non-discarded data_ok arrives, that entry drives the ID outputs combinationally in the same cycle.
  - If id_allowin=1, the entry is consumed and not written to the buffer.
  - Otherwise it is written to the buffer.
- Undefined: data_ok always writes the buffer; minimum latency is 1 cycle.

Decomposition:
- Shared package if_pkg: RESET_PC default, the inst_sram size encoding SIZE_WORD=2'b10, and the buffer entry typedef {pc[31:0], inst[31:0], adef}.
- One natural sub-module: if_sync_fifo (parametrised WIDTH/DEPTH, with count output and synchronous clear). It is instantiated twice: pending PCs (WIDTH=32) and instruction buffer (WIDTH=65).

Test Plan:
- Straight-line fetch, addr_ok always 1, data_ok 2 cycles later, MAX_OUTSTANDING=2 -> PCs 1c000000, 1c000004, 1c000008... reach ID in order; never more than 2 requests unanswered.
- id_allowin=0 for 10 cycles -> issue stops once pending_cnt+buf_cnt=4; no entry lost; PC order resumes when released.
- br_valid at target 1c000100 with 2 requests outstanding -> next 2 data_ok dropped; first ID instruction has if_pc=1c000100.
- flush and br_valid in the same cycle (flush_target 1c008000, br_target 1c000200) -> fetch resumes at 1c008000.
- br_target=1c000102 -> no inst_sram_req; one entry reaches ID with if_adef=1, if_inst=0; no further fetch until a redirect to 1c000200.
- With IF_BYPASS_EN, buffer empty, id_allowin=1 -> if_to_id_valid is high in the data_ok cycle. Without it -> high 1 cycle later.

Source files
------------

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch front end: reset PC default,
// inst_sram size encoding and the instruction-buffer entry layout.
package if_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
    localparam logic [1:0]  SIZE_WORD        = 2'b10;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } buf_entry_t;

endpackage

// File: rtl/if_sync_fifo.sv
// Small synchronous FIFO with occupancy count and a synchronous clear.
// Push while full is accepted only when a pop happens in the same cycle.
// The head entry is presented combinationally on o_headData.
module if_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_pushData,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_headData,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_doPush;
    logic             w_doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_doPop    = i_pop & ~w_empty & ~i_clear;
    assign w_doPush   = i_push & (~w_full | w_doPop) & ~i_clear;
    assign o_headData = r_mem[r_rdPtr];
    assign o_count    = r_count;

    // Storage array: written at the tail pointer, no reset needed.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= nextPtr(r_wrPtr);
            if (w_doPop)  r_rdPtr <= nextPtr(r_rdPtr);
            if (w_doPush && !w_doPop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_doPush && w_doPop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_fetch_mo.sv
// Multi-outstanding instruction-fetch front end. Keeps several inst_sram
// requests in flight, remembers their PCs in a pending FIFO and queues the
// returned instructions in a buffer feeding ID. Redirects turn every request
// still in flight into a "discard" credit so stale responses are dropped.
// Optional build macro: IF_BYPASS_EN -- when the buffer is empty a live
// response drives the ID outputs in the same cycle it arrives.
module if_fetch_mo
    import if_pkg::*;
#(
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          BUF_DEPTH       = 4,
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        flush,
    input  logic [31:0] flush_target,
    input  logic        id_allowin,
    output logic        if_to_id_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_adef,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    localparam int PEND_CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int BUF_CW  = $clog2(BUF_DEPTH + 1);

    logic [31:0]        r_pcNext;
    logic               r_stop;
    logic [PEND_CW-1:0] r_discardCnt;

    logic               w_redirect;
    logic [31:0]        w_target;
    logic               w_aligned;
    logic [PEND_CW-1:0] w_pendCnt;
    logic [BUF_CW-1:0]  w_bufCnt;
    logic [31:0]        w_pendHead;
    logic [31:0]        w_inflight;
    logic [31:0]        w_credit;
    logic [31:0]        w_discardSum;
    logic               w_issue;
    logic               w_respLive;
    logic               w_respDrop;
    logic               w_adefPush;
    logic               w_bufEmpty;
    logic               w_bufFull;
    logic               w_bufPush;
    logic               w_bufPop;
    logic               w_bypass;
    logic               w_headValid;
    buf_entry_t         w_respEntry;
    buf_entry_t         w_adefEntry;
    buf_entry_t         w_bufPushData;
    buf_entry_t         w_bufHead;
    buf_entry_t         w_headEntry;

    assign w_redirect = flush | br_valid;
    assign w_target   = flush ? flush_target : br_target;
    assign w_aligned  = (r_pcNext[1:0] == 2'b00);

    assign w_inflight = 32'(w_pendCnt) + 32'(r_discardCnt);
    assign w_credit   = 32'(w_pendCnt) + 32'(w_bufCnt);
    assign w_bufEmpty = (w_bufCnt == '0);
    assign w_bufFull  = (w_bufCnt == BUF_CW'(BUF_DEPTH));

    assign inst_sram_req = ~reset & ~r_stop & ~w_redirect & w_aligned
                         & (w_inflight < 32'(MAX_OUTSTANDING))
                         & (w_credit < 32'(BUF_DEPTH));
    assign inst_sram_addr  = r_pcNext;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = SIZE_WORD;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_wdata = 32'h0;

    assign w_issue    = inst_sram_req & inst_sram_addr_ok;
    assign w_respLive = inst_sram_data_ok & (r_discardCnt == '0) & ~w_redirect;
    assign w_respDrop = inst_sram_data_ok & (r_discardCnt != '0);

    // A misaligned fetch waits for older live requests to drain so the
    // exception entry lands behind them in program order.
    assign w_adefPush = ~w_redirect & ~r_stop & ~w_aligned
                      & (w_pendCnt == '0) & ~w_bufFull;

    // A data_ok in the redirect cycle consumes one in-flight slot whether it
    // was live or already stale, so it is removed from the discard total.
    assign w_discardSum = w_inflight - {31'b0, inst_sram_data_ok};

    assign w_respEntry = '{pc: w_pendHead, inst: inst_sram_rdata, adef: 1'b0};
    assign w_adefEntry = '{pc: r_pcNext, inst: 32'h0, adef: 1'b1};

`ifdef IF_BYPASS_EN
    assign w_bypass = w_bufEmpty & w_respLive;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_bufPushData = w_adefPush ? w_adefEntry : w_respEntry;
    assign w_bufPush     = w_adefPush | (w_respLive & ~(w_bypass & id_allowin));
    assign w_bufPop      = ~w_bufEmpty & id_allowin;
    assign w_headEntry   = w_bypass ? w_respEntry : w_bufHead;
    assign w_headValid   = ~w_bufEmpty | w_bypass;

    assign if_to_id_valid = w_headValid;
    assign if_pc          = w_headValid ? w_headEntry.pc   : 32'h0;
    assign if_inst        = w_headValid ? w_headEntry.inst : 32'h0;
    assign if_adef        = w_headValid & w_headEntry.adef;

    // Fetch PC, stop flag and stale-response credit tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcNext     <= RESET_PC;
            r_stop       <= 1'b0;
            r_discardCnt <= '0;
        end else if (w_redirect) begin
            r_pcNext     <= w_target;
            r_stop       <= 1'b0;
            r_discardCnt <= PEND_CW'(w_discardSum);
        end else begin
            if (w_issue)    r_pcNext     <= r_pcNext + 32'd4;
            if (w_adefPush) r_stop       <= 1'b1;
            if (w_respDrop) r_discardCnt <= r_discardCnt - 1'b1;
        end
    end

    if_sync_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pendFifo (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_redirect),
        .i_push     (w_issue),
        .i_pushData (r_pcNext),
        .i_pop      (w_respLive),
        .o_headData (w_pendHead),
        .o_count    (w_pendCnt)
    );

    if_sync_fifo #(
        .WIDTH ($bits(buf_entry_t)),
        .DEPTH (BUF_DEPTH)
    ) u_instBuf (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_redirect),
        .i_push     (w_bufPush),
        .i_pushData (w_bufPushData),
        .i_pop      (w_bufPop),
        .o_headData (w_bufHead),
        .o_count    (w_bufCnt)
    );

endmodule

// File: tb/tb_if_fetch_mo.sv
// Directed bench for if_fetch_mo. An inst_sram model accepts every request
// and answers in order two cycles later with rdata = ~address. A scoreboard
// tracks the PC ID should see next from the latest reset/redirect target.
module tb_if_fetch_mo;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;
`ifdef IF_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] flush_target = 32'h0;
    logic        id_allowin = 1'b0;
    logic        if_to_id_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adef;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok = 1'b0;
    logic        inst_sram_data_ok = 1'b0;
    logic [31:0] inst_sram_rdata = 32'h0;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] memQ[$];
    int          memDue[$];
    int          cycle = 0;
    int          reqCount = 0;
    int          xferCount = 0;
    int          firstDataOk = -1;
    int          firstValid = -1;
    logic [31:0] expPc = RST_PC;
    bit          expStopped = 1'b0;
    logic [31:0] lastPc = 32'h0;
    logic [31:0] lastInst = 32'h0;
    logic        lastAdef = 1'b0;
    int          reqBase;
    int          xferBase;

    if_fetch_mo dut (
        .clk               (clk),
        .reset             (reset),
        .br_valid          (br_valid),
        .br_target         (br_target),
        .flush             (flush),
        .flush_target      (flush_target),
        .id_allowin        (id_allowin),
        .if_to_id_valid    (if_to_id_valid),
        .if_pc             (if_pc),
        .if_inst           (if_inst),
        .if_adef           (if_adef),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive memory outputs, sample DUT, update models.
    task automatic applyStimulus();
        if (reset) begin
            memQ.delete();
            memDue.delete();
            expPc = RST_PC;
            expStopped = 1'b0;
            firstDataOk = -1;
            firstValid = -1;
        end
        inst_sram_addr_ok = 1'b1;
        if (memQ.size() > 0 && memDue[0] <= cycle) begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata   = ~memQ[0];
        end else begin
            inst_sram_data_ok = 1'b0;
            inst_sram_rdata   = 32'h0;
        end
        #1;
        if (!reset) begin
            if (inst_sram_data_ok && firstDataOk < 0) firstDataOk = cycle;
            if (if_to_id_valid && firstValid < 0) firstValid = cycle;
            if (inst_sram_req && inst_sram_addr_ok) begin
                memQ.push_back(inst_sram_addr);
                memDue.push_back(cycle + 2);
                reqCount++;
            end
            if (inst_sram_data_ok) begin
                void'(memQ.pop_front());
                void'(memDue.pop_front());
            end
            checkOutput("outstandingLimit", {31'b0, memQ.size() <= 2}, 32'd1);
            if (if_to_id_valid && id_allowin) begin
                xferCount++;
                lastPc = if_pc;
                lastInst = if_inst;
                lastAdef = if_adef;
                if (expStopped) begin
                    checkOutput("xferAfterAdef", {31'b0, if_to_id_valid}, 32'd0);
                end else if (expPc[1:0] != 2'b00) begin
                    checkOutput("idPc", if_pc, expPc);
                    checkOutput("idInst", if_inst, 32'h0);
                    checkOutput("idAdef", {31'b0, if_adef}, 32'd1);
                    expStopped = 1'b1;
                end else begin
                    checkOutput("idPc", if_pc, expPc);
                    checkOutput("idInst", if_inst, ~expPc);
                    checkOutput("idAdef", {31'b0, if_adef}, 32'd0);
                    expPc = expPc + 32'd4;
                end
            end
            if (flush) begin
                expPc = flush_target;
                expStopped = 1'b0;
            end else if (br_valid) begin
                expPc = br_target;
                expStopped = 1'b0;
            end
        end
        @(posedge clk);
        cycle++;
        @(negedge clk);
    endtask

    task automatic waitQueue(input int n);
        for (int i = 0; i < 50; i++) begin
            if (memQ.size() == n) break;
            applyStimulus();
        end
        if (memQ.size() != n) checkOutput("waitQueueTimeout", memQ.size(), n);
    endtask

    task automatic waitXfer();
        int x0;
        x0 = xferCount;
        for (int i = 0; i < 50; i++) begin
            if (xferCount > x0) break;
            applyStimulus();
        end
        if (xferCount == x0) checkOutput("waitXferTimeout", xferCount, x0 + 1);
    endtask

    initial begin
        @(negedge clk);
        reset = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("rstReq", {31'b0, inst_sram_req}, 32'd0);
        checkOutput("rstValid", {31'b0, if_to_id_valid}, 32'd0);
        checkOutput("rstPc", if_pc, 32'h0);
        checkOutput("rstInst", if_inst, 32'h0);
        checkOutput("rstAdef", {31'b0, if_adef}, 32'd0);
        checkOutput("sramSize", {30'b0, inst_sram_size}, 32'd2);

        // Straight-line fetch
        reset = 1'b0;
        id_allowin = 1'b1;
        #1;
        checkOutput("firstReq", {31'b0, inst_sram_req}, 32'd1);
        checkOutput("firstAddr", inst_sram_addr, RST_PC);
        repeat (20) applyStimulus();
        checkOutput("fetchLatency", 32'(firstValid - firstDataOk), 32'(LAT));
        checkOutput("straightProgress", {31'b0, xferCount >= 8}, 32'd1);

        // ID back-pressure: buffer fills, issue stops, nothing lost
        id_allowin = 1'b0;
        repeat (12) applyStimulus();
        checkOutput("stallNoReq", {31'b0, inst_sram_req}, 32'd0);
        checkOutput("stallQueueEmpty", memQ.size(), 32'd0);
        checkOutput("stallValid", {31'b0, if_to_id_valid}, 32'd1);
        xferBase = xferCount;
        id_allowin = 1'b1;
        repeat (12) applyStimulus();
        checkOutput("stallDrain", {31'b0, (xferCount - xferBase) >= 4}, 32'd1);

        // Branch with two requests outstanding
        waitQueue(2);
        br_valid = 1'b1;
        br_target = 32'h1c00_0100;
        applyStimulus();
        br_valid = 1'b0;
        waitXfer();
        checkOutput("brFirstPc", lastPc, 32'h1c00_0100);
        checkOutput("brFirstInst", lastInst, ~32'h1c00_0100);
        repeat (6) applyStimulus();

        // Flush wins over a simultaneous branch
        flush = 1'b1;
        flush_target = 32'h1c00_8000;
        br_valid = 1'b1;
        br_target = 32'h1c00_0200;
        applyStimulus();
        flush = 1'b0;
        br_valid = 1'b0;
        waitXfer();
        checkOutput("flushFirstPc", lastPc, 32'h1c00_8000);
        repeat (4) applyStimulus();

        // Misaligned branch target
        br_valid = 1'b1;
        br_target = 32'h1c00_0102;
        applyStimulus();
        br_valid = 1'b0;
        reqBase = reqCount;
        xferBase = xferCount;
        repeat (12) applyStimulus();
        checkOutput("adefNoReq", reqCount - reqBase, 32'd0);
        checkOutput("adefOneXfer", xferCount - xferBase, 32'd1);
        checkOutput("adefPc", lastPc, 32'h1c00_0102);
        checkOutput("adefInst", lastInst, 32'h0);
        checkOutput("adefBit", {31'b0, lastAdef}, 32'd1);
        checkOutput("adefStopReq", {31'b0, inst_sram_req}, 32'd0);
        br_valid = 1'b1;
        br_target = 32'h1c00_0200;
        applyStimulus();
        br_valid = 1'b0;
        waitXfer();
        checkOutput("resumePc", lastPc, 32'h1c00_0200);
        repeat (3) applyStimulus();

        // Reset in the middle of traffic
        reset = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("rst2Valid", {31'b0, if_to_id_valid}, 32'd0);
        checkOutput("rst2Req", {31'b0, inst_sram_req}, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("rst2Addr", inst_sram_addr, RST_PC);
        repeat (15) applyStimulus();
        checkOutput("rst2Latency", 32'(firstValid - firstDataOk), 32'(LAT));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
